// File: rtl/alarm_pkg.sv
// Shared types and helpers for the door-alarm controller.
//   state_t  : FSM state encoding, also exported on state_o
//   CNT_W    : width of the entry/siren timer
//   hex7seg  : hex digit to active-high 7-segment pattern (a=bit0 .. g=bit6)
package alarm_pkg;

   localparam int unsigned CNT_W = 8;

   typedef enum logic [2:0] {
      DISARMED = 3'd0,
      ARMED    = 3'd1,
      ENTRY    = 3'd2,
      ALARM    = 3'd3,
      HOLD     = 3'd4
   } state_t;

   function automatic logic [6:0] hex7seg(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/alarm_controller_door_debounce.sv
// Door sensor conditioning: 2-flop synchroniser followed by a stability filter.
// door_db adopts the synchronised value once it has differed from door_db for
// DEB_CYC consecutive cycles; raw edge to door_db edge is 2+DEB_CYC cycles.
// Ports:
//   clk_2     in  board clock
//   rst_n     in  async active-low reset
//   door_open in  raw door sensor (asynchronous)
//   door_db   out debounced door state
module door_debounce #(
   parameter int unsigned DEB_CYC = 2
) (
   input  logic clk_2,
   input  logic rst_n,
   input  logic door_open,
   output logic door_db
);

   localparam int unsigned DEB_W = 4;

   logic             sync_1;
   logic             sync_2;
   logic [DEB_W-1:0] stable_cnt;

   // Synchroniser and stability counter; counter restarts whenever the
   // synced value falls back to the current debounced value.
   always_ff @(posedge clk_2 or negedge rst_n) begin
      if (!rst_n) begin
         sync_1     <= 1'b0;
         sync_2     <= 1'b0;
         stable_cnt <= '0;
         door_db    <= 1'b0;
      end else begin
         sync_1 <= door_open;
         sync_2 <= sync_1;
         if (sync_2 == door_db) begin
            stable_cnt <= '0;
         end else if (stable_cnt == DEB_W'(DEB_CYC - 1)) begin
            stable_cnt <= '0;
            door_db    <= sync_2;
         end else begin
            stable_cnt <= stable_cnt + DEB_W'(1);
         end
      end
   end

endmodule

// File: rtl/alarm_controller.sv
// Sequenced door-alarm controller: arms on night/force_arm, runs an entry delay
// when the door opens, then a blinking siren with a latched alarm until ack.
// Optional feature macro: ALARM_SEG_EN (7-segment display of count_o[3:0] plus
// alarm on the decimal point); without it SEG is tied low.
// Ports:
//   clk_2, rst_n                 clock, async active-low reset
//   door_open, night, force_arm  sensor and arm inputs
//   ack                          alarm acknowledge
//   alarm_o, siren_o             latched alarm, toggling siren drive
//   state_o, count_o             current state, remaining timer cycles
//   SEG                          7-segment drive
module alarm_controller
   import alarm_pkg::*;
#(
   parameter int unsigned DELAY_CYC = 5,
   parameter int unsigned SIREN_CYC = 10,
   parameter int unsigned DEB_CYC   = 2
) (
   input  logic             clk_2,
   input  logic             rst_n,
   input  logic             door_open,
   input  logic             night,
   input  logic             force_arm,
   input  logic             ack,
   output logic             alarm_o,
   output logic             siren_o,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] count_o,
   output logic [7:0]       SEG
);

   state_t           state, state_nx;
   logic [CNT_W-1:0] count, count_nx;
   logic             alarm, alarm_nx;
   logic             siren, siren_nx;
   logic             door_db;
   logic             arm_c;

   door_debounce #(.DEB_CYC(DEB_CYC)) u_door_debounce (
      .clk_2     (clk_2),
      .rst_n     (rst_n),
      .door_open (door_open),
      .door_db   (door_db)
   );

   assign arm_c = night | force_arm;

   // State and output registers.
   always_ff @(posedge clk_2 or negedge rst_n) begin
      if (!rst_n) begin
         state <= DISARMED;
         count <= '0;
         alarm <= 1'b0;
         siren <= 1'b0;
      end else begin
         state <= state_nx;
         count <= count_nx;
         alarm <= alarm_nx;
         siren <= siren_nx;
      end
   end

   // Next-state, timer and output logic; count<=1 tests guard against underflow.
   always_comb begin
      state_nx = state;
      count_nx = count;
      alarm_nx = alarm;
      siren_nx = siren;
      case (state)
         DISARMED: begin
            count_nx = '0;
            alarm_nx = 1'b0;
            siren_nx = 1'b0;
            if (arm_c && !door_db) state_nx = ARMED;
         end
         ARMED: begin
            count_nx = '0;
            if (!arm_c) begin
               state_nx = DISARMED;
            end else if (door_db) begin
               state_nx = ENTRY;
               count_nx = CNT_W'(DELAY_CYC);
            end
         end
         ENTRY: begin
            if (!arm_c) begin
               state_nx = DISARMED;
               count_nx = '0;
            end else if (count <= CNT_W'(1)) begin
               state_nx = ALARM;
               count_nx = CNT_W'(SIREN_CYC);
               alarm_nx = 1'b1;
               siren_nx = 1'b1;
            end else begin
               count_nx = count - CNT_W'(1);
            end
         end
         ALARM: begin
            if (ack) begin
               count_nx = '0;
               siren_nx = 1'b0;
               if (!door_db) begin
                  state_nx = DISARMED;
                  alarm_nx = 1'b0;
               end else begin
                  state_nx = HOLD;
               end
            end else if (count <= CNT_W'(1)) begin
               state_nx = HOLD;
               count_nx = '0;
               siren_nx = 1'b0;
            end else begin
               count_nx = count - CNT_W'(1);
               siren_nx = !siren;
            end
         end
         HOLD: begin
            count_nx = '0;
            siren_nx = 1'b0;
            alarm_nx = 1'b1;
            if (ack && !door_db) begin
               state_nx = DISARMED;
               alarm_nx = 1'b0;
            end
         end
         default: begin
            state_nx = DISARMED;
            count_nx = '0;
            alarm_nx = 1'b0;
            siren_nx = 1'b0;
         end
      endcase
   end

   assign state_o = state;
   assign count_o = count;
   assign alarm_o = alarm;
   assign siren_o = siren;

`ifdef ALARM_SEG_EN
   logic [7:0] seg_q;

   // Display is decoded from next-state values so it stays aligned with count_o.
   always_ff @(posedge clk_2 or negedge rst_n) begin
      if (!rst_n) begin
         seg_q <= 8'h00;
      end else begin
         seg_q <= {alarm_nx, hex7seg(count_nx[3:0])};
      end
   end

   assign SEG = seg_q;
`else
   assign SEG = 8'h00;
`endif

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller (defaults DELAY_CYC=5, SIREN_CYC=10, DEB_CYC=2).
module tb_alarm_controller;

   logic       clk_2 = 1'b0;
   logic       rst_n = 1'b0;
   logic       door_open = 1'b0;
   logic       night = 1'b0;
   logic       force_arm = 1'b0;
   logic       ack = 1'b0;
   logic       alarm_o;
   logic       siren_o;
   logic [2:0] state_o;
   logic [7:0] count_o;
   logic [7:0] SEG;

   int n_cmp = 0;
   int n_err = 0;

   alarm_controller dut (
      .clk_2     (clk_2),
      .rst_n     (rst_n),
      .door_open (door_open),
      .night     (night),
      .force_arm (force_arm),
      .ack       (ack),
      .alarm_o   (alarm_o),
      .siren_o   (siren_o),
      .state_o   (state_o),
      .count_o   (count_o),
      .SEG       (SEG)
   );

   always #5 clk_2 = ~clk_2;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance n rising edges; inputs change and outputs are sampled on falling edges.
   task automatic step(input int n);
      repeat (n) @(negedge clk_2);
   endtask

   initial begin
      // Reset values
      step(2);
      check_val("rst_state", 32'(state_o), 0);
      check_val("rst_count", 32'(count_o), 0);
      check_val("rst_alarm", 32'(alarm_o), 0);
      check_val("rst_siren", 32'(siren_o), 0);
      check_val("rst_seg", 32'(SEG), 0);
      rst_n = 1'b1;
      step(1);

      // Arm with door closed: ARMED next edge
      night = 1'b1;
      step(1);
      check_val("arm_closed", 32'(state_o), 1);
      night = 1'b0;
      step(1);
      check_val("disarm", 32'(state_o), 0);

      // No arming while debounced door is open
      door_open = 1'b1;
      step(5);
      night = 1'b1;
      step(2);
      check_val("arm_door_open", 32'(state_o), 0);
      door_open = 1'b0;
      step(4);
      check_val("arm_deb_wait", 32'(state_o), 0);
      step(1);
      check_val("arm_after_close", 32'(state_o), 1);

      // Entry delay then siren then HOLD
      door_open = 1'b1;
      step(4);
      check_val("entry_latency", 32'(state_o), 1);
      step(1);
      check_val("entry_state", 32'(state_o), 2);
      check_val("entry_count5", 32'(count_o), 5);
`ifdef ALARM_SEG_EN
      check_val("seg_count5", 32'(SEG), 32'h6D);
`else
      check_val("seg_off", 32'(SEG), 0);
`endif
      for (int k = 1; k <= 4; k++) begin
         step(1);
         check_val("entry_count", 32'(count_o), 32'(5 - k));
         check_val("entry_hold_state", 32'(state_o), 2);
      end
      step(1);
      check_val("alarm_state", 32'(state_o), 3);
      check_val("alarm_count10", 32'(count_o), 10);
      check_val("alarm_latched", 32'(alarm_o), 1);
      check_val("siren_first", 32'(siren_o), 1);
`ifdef ALARM_SEG_EN
      check_val("seg_count10", 32'(SEG), 32'hF7);
`endif
      for (int k = 1; k <= 9; k++) begin
         step(1);
         check_val("alarm_count", 32'(count_o), 32'(10 - k));
         check_val("siren_toggle", 32'(siren_o), (k % 2 == 0) ? 1 : 0);
      end
      step(1);
      check_val("hold_state", 32'(state_o), 4);
      check_val("hold_siren", 32'(siren_o), 0);
      check_val("hold_alarm", 32'(alarm_o), 1);
      check_val("hold_count", 32'(count_o), 0);
      ack = 1'b1;
      step(1);
      check_val("hold_ack_open", 32'(state_o), 4);
      door_open = 1'b0;
      step(4);
      check_val("hold_deb_wait", 32'(state_o), 4);
      step(1);
      check_val("hold_release", 32'(state_o), 0);
      check_val("hold_release_alarm", 32'(alarm_o), 0);
      ack = 1'b0;

      // Cancel during entry at count 3
      step(1);
      check_val("cancel_armed", 32'(state_o), 1);
      door_open = 1'b1;
      step(5);
      step(2);
      check_val("cancel_count3", 32'(count_o), 3);
      night = 1'b0;
      step(1);
      check_val("cancel_state", 32'(state_o), 0);
      check_val("cancel_count", 32'(count_o), 0);
      door_open = 1'b0;
      step(5);
      night = 1'b1;

      // Ack in ALARM with door closed
      step(1);
      door_open = 1'b1;
      step(5);
      check_val("ackc_entry", 32'(state_o), 2);
      door_open = 1'b0;
      step(5);
      check_val("ackc_alarm", 32'(state_o), 3);
      step(2);
      check_val("ackc_count8", 32'(count_o), 8);
      ack = 1'b1;
      step(1);
      check_val("ackc_state", 32'(state_o), 0);
      check_val("ackc_alarm_clr", 32'(alarm_o), 0);
      check_val("ackc_siren_clr", 32'(siren_o), 0);
      check_val("ackc_count", 32'(count_o), 0);
      ack = 1'b0;

      // Ack in ALARM with door open -> HOLD until close + ack
      step(1);
      door_open = 1'b1;
      step(10);
      check_val("acko_alarm", 32'(state_o), 3);
      ack = 1'b1;
      step(1);
      check_val("acko_hold", 32'(state_o), 4);
      check_val("acko_alarm_o", 32'(alarm_o), 1);
      check_val("acko_siren", 32'(siren_o), 0);
      ack = 1'b0;
      door_open = 1'b0;
      step(6);
      check_val("acko_no_ack", 32'(state_o), 4);
      ack = 1'b1;
      step(1);
      check_val("acko_release", 32'(state_o), 0);
      ack = 1'b0;

      // Disarm ignored in ALARM; ack beats timeout
      step(1);
      door_open = 1'b1;
      step(5);
      door_open = 1'b0;
      step(5);
      check_val("to_alarm", 32'(count_o), 10);
      step(5);
      check_val("to_count5", 32'(count_o), 5);
`ifdef ALARM_SEG_EN
      check_val("to_seg5", 32'(SEG), 32'hED);
`endif
      night = 1'b0;
      step(1);
      check_val("to_disarm_ignored", 32'(state_o), 3);
      step(3);
      check_val("to_count1", 32'(count_o), 1);
      ack = 1'b1;
      step(1);
      check_val("to_ack_priority", 32'(state_o), 0);
      check_val("to_ack_alarm", 32'(alarm_o), 0);
      ack = 1'b0;
      night = 1'b1;

      // One-cycle door glitch must not start entry
      step(1);
      check_val("glitch_armed", 32'(state_o), 1);
      door_open = 1'b1;
      step(1);
      door_open = 1'b0;
      step(8);
      check_val("glitch_no_entry", 32'(state_o), 1);

      // Asynchronous reset mid-ALARM
      door_open = 1'b1;
      step(10);
      step(1);
      check_val("mid_alarm", 32'(state_o), 3);
      rst_n = 1'b0;
      #1;
      check_val("mrst_state", 32'(state_o), 0);
      check_val("mrst_count", 32'(count_o), 0);
      check_val("mrst_alarm", 32'(alarm_o), 0);
      check_val("mrst_siren", 32'(siren_o), 0);
      check_val("mrst_seg", 32'(SEG), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
